// File: rtl/st_adapter_pkg.sv
// Shared constants, FSM state type and helpers for the streaming width adapters.
// Used by st_pack_64_512 (64-bit beats packed into 512-bit words).
package st_adapter_pkg;

    localparam int unsigned ST_IN_W    = 64;
    localparam int unsigned ST_OUT_W   = 512;
    localparam int unsigned ST_LANES   = ST_OUT_W / ST_IN_W;
    localparam int unsigned ST_LANE_W  = 3;
    localparam int unsigned ST_EMPTY_W = 6;

    localparam logic [ST_LANE_W-1:0] ST_LAST_LANE = 3'd7;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StHold = 2'd2
    } st_state_e;

    // Empty bytes of a word whose last valid beat sits in `lane`.
    function automatic logic [ST_EMPTY_W-1:0] calc_empty(input logic [ST_LANE_W-1:0] lane,
                                                          input logic [2:0]           in_empty);
        logic [ST_LANE_W-1:0] unused_lanes;
        unused_lanes = ST_LAST_LANE - lane;
        return {unused_lanes, 3'b000} + {3'b000, in_empty};
    endfunction

endpackage

// File: rtl/st_pack_64_512.sv
// Packs a 64-bit packet stream into 512-bit words (8 lanes), with framing-error detection.
// Define ST_PACK_DOUBLE_BUF_EN for a separate output register (one beat per cycle sustained).
module st_pack_64_512
    import st_adapter_pkg::*;
#(
    parameter int unsigned IN_W  = ST_IN_W,
    parameter int unsigned OUT_W = ST_OUT_W
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_data,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic [2:0]            in_empty,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [ST_EMPTY_W-1:0] out_empty,

    output logic                  err
);

    st_state_e state_q, state_d;

    logic [ST_LANE_W-1:0]  lane_q, lane_d;
    logic [OUT_W-1:0]      fb_q, fb_d;
    logic                  first_q, first_d;
    logic                  pend_sop_q, pend_sop_d;
    logic                  pend_eop_q, pend_eop_d;
    logic [ST_EMPTY_W-1:0] pend_empty_q, pend_empty_d;
    logic                  rdy_en_q;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  drop;
    logic                  abort;
    logic                  write;
    logic                  complete;
    logic                  word_sop;
    logic [ST_LANE_W-1:0]  lane_w;
    logic [ST_EMPTY_W-1:0] word_empty;
    logic [OUT_W-1:0]      merged;

`ifdef ST_PACK_DOUBLE_BUF_EN
    logic [OUT_W-1:0]      ob_q, ob_d;
    logic                  ob_valid_q, ob_valid_d;
    logic                  ob_sop_q, ob_sop_d;
    logic                  ob_eop_q, ob_eop_d;
    logic [ST_EMPTY_W-1:0] ob_empty_q, ob_empty_d;
    logic                  ob_free;
    logic                  handshake;

    assign handshake = ob_valid_q & out_ready;
    assign ob_free   = ~ob_valid_q | out_ready;
`endif

    // rdy_en_q keeps in_ready low through reset and raises it on the first edge after release.
    assign in_ready = rdy_en_q & (state_q != StHold);
    assign accept   = in_valid & in_ready;
    assign drop     = accept & (state_q == StIdle) & ~in_sop;
    assign abort    = accept & in_sop & (state_q == StFill) & (lane_q != '0);
    assign write    = accept & ~drop;
    assign lane_w   = in_sop ? '0 : lane_q;
    assign complete = write & (in_eop | (lane_w == ST_LAST_LANE));
    assign word_sop = in_sop | first_q;

    assign word_empty = in_eop ? calc_empty(lane_w, in_empty) : '0;

    // Lane writer: lanes below the write lane keep buffered data, lanes above read as zero,
    // so a finished word never carries stale beats from an earlier word.
    for (genvar k = 0; k < ST_LANES; k++) begin : g_lane
        localparam logic [ST_LANE_W-1:0] Lane = ST_LANE_W'(k);
        assign merged[k*IN_W +: IN_W] = (Lane == lane_w) ? in_data                 :
                                        (Lane <  lane_w) ? fb_q[k*IN_W +: IN_W]    :
                                                           '0;
    end

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        fb_d         = fb_q;
        first_d      = first_q;
        pend_sop_d   = pend_sop_q;
        pend_eop_d   = pend_eop_q;
        pend_empty_d = pend_empty_q;
        err_d        = drop | abort;
`ifdef ST_PACK_DOUBLE_BUF_EN
        ob_d         = ob_q;
        ob_valid_d   = ob_valid_q;
        ob_sop_d     = ob_sop_q;
        ob_eop_d     = ob_eop_q;
        ob_empty_d   = ob_empty_q;
        if (handshake) begin
            ob_valid_d = 1'b0;
            ob_sop_d   = 1'b0;
            ob_eop_d   = 1'b0;
            ob_empty_d = '0;
        end
`endif

        if (write) begin
            fb_d = merged;
            if (complete) begin
                lane_d  = '0;
                first_d = 1'b0;
            end else begin
                lane_d  = lane_w + 1'b1;
                first_d = word_sop;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (write) state_d = StFill;
            end
            StFill: begin
                state_d = StFill;
            end
            StHold: begin
`ifdef ST_PACK_DOUBLE_BUF_EN
                if (handshake) begin
                    ob_d       = fb_q;
                    ob_valid_d = 1'b1;
                    ob_sop_d   = pend_sop_q;
                    ob_eop_d   = pend_eop_q;
                    ob_empty_d = pend_empty_q;
`else
                if (out_ready) begin
`endif
                    state_d      = pend_eop_q ? StIdle : StFill;
                    pend_sop_d   = 1'b0;
                    pend_eop_d   = 1'b0;
                    pend_empty_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Completion only happens in IDLE/FILL since in_ready is low in HOLD.
        if (complete) begin
`ifdef ST_PACK_DOUBLE_BUF_EN
            if (ob_free) begin
                ob_d       = merged;
                ob_valid_d = 1'b1;
                ob_sop_d   = word_sop;
                ob_eop_d   = in_eop;
                ob_empty_d = word_empty;
                state_d    = in_eop ? StIdle : StFill;
            end else begin
                state_d      = StHold;
                pend_sop_d   = word_sop;
                pend_eop_d   = in_eop;
                pend_empty_d = word_empty;
            end
`else
            state_d      = StHold;
            pend_sop_d   = word_sop;
            pend_eop_d   = in_eop;
            pend_empty_d = word_empty;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            lane_q       <= '0;
            fb_q         <= '0;
            first_q      <= 1'b0;
            pend_sop_q   <= 1'b0;
            pend_eop_q   <= 1'b0;
            pend_empty_q <= '0;
            rdy_en_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            fb_q         <= fb_d;
            first_q      <= first_d;
            pend_sop_q   <= pend_sop_d;
            pend_eop_q   <= pend_eop_d;
            pend_empty_q <= pend_empty_d;
            rdy_en_q     <= 1'b1;
            err_q        <= err_d;
        end
    end

`ifdef ST_PACK_DOUBLE_BUF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ob_q       <= '0;
            ob_valid_q <= 1'b0;
            ob_sop_q   <= 1'b0;
            ob_eop_q   <= 1'b0;
            ob_empty_q <= '0;
        end else begin
            ob_q       <= ob_d;
            ob_valid_q <= ob_valid_d;
            ob_sop_q   <= ob_sop_d;
            ob_eop_q   <= ob_eop_d;
            ob_empty_q <= ob_empty_d;
        end
    end

    assign out_valid = ob_valid_q;
    assign out_data  = ob_q;
    assign out_sop   = ob_sop_q;
    assign out_eop   = ob_eop_q;
    assign out_empty = ob_empty_q;
`else
    // Single buffer: the fill buffer itself is the output while in HOLD.
    assign out_valid = (state_q == StHold);
    assign out_data  = fb_q;
    assign out_sop   = pend_sop_q;
    assign out_eop   = pend_eop_q;
    assign out_empty = pend_empty_q;
`endif

    assign err = err_q;

endmodule

// File: doc/st_pack_64_512.md
ST_PACK_64_512 -- requirements
Module: st_pack_64_512

Interface
REQ-001 SHALL have parameter IN_W, default 64, input beat width (fixed, not overridable).
REQ-002 SHALL have parameter OUT_W, default 512, output word width; OUT_W/IN_W = 8 lanes.
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, in_data input 64, in_sop input 1, in_eop input 1, in_empty input 3 (empty bytes in the eop beat).
REQ-006 SHALL have ports out_valid output 1, out_ready input 1, out_data output 512, out_sop output 1, out_eop output 1, out_empty output 6 (empty bytes in the eop word).
REQ-007 SHALL have port err output 1, a one-cycle pulse on a framing error.

Function
REQ-008 SHALL accept a beat only when in_valid and in_ready are both high, and emit a word only when out_valid and out_ready are both high.
REQ-009 SHALL place beat k of a word (k = 0..7) in out_data[64k +: 64]; the first beat of a packet goes to lane 0.
REQ-010 SHALL use a 3-bit lane counter: it resets to 0 on reset, on a completed word, and on an accepted in_sop beat (which is written to lane 0).
REQ-011 SHALL complete a word on an accepted beat at lane 7 or on any accepted beat with in_eop, whichever comes first.
REQ-012 SHALL zero unused lanes above the eop lane in out_data.
REQ-013 SHALL set out_empty to (7 - lane)*8 + in_empty on an eop word and to 0 otherwise.
REQ-014 SHALL set out_sop on the first word of a packet and out_eop on the word completed by in_eop; both can be set on a single-word packet.
REQ-015 SHALL present a completed word on out_valid in the cycle after the completing beat is accepted (latency 1), holding data and flags stable until it is accepted.
REQ-016 SHALL implement the states IDLE (no packet open), FILL (packet open) and HOLD (completed word waiting, fill path stalled).
REQ-017 SHALL make these state transitions:
- IDLE -> FILL on an accepted in_sop beat.
- FILL -> HOLD on word completion while the output is occupied.
- HOLD -> FILL, or HOLD -> IDLE after eop, on an output handshake.
- FILL -> IDLE after an eop word is transferred.
REQ-018 SHALL, on an accepted beat in IDLE without in_sop, drop the beat and pulse err.
REQ-019 SHALL, on an accepted in_sop beat in FILL with lane != 0, discard the partial word, pulse err, and start a new packet at lane 0.
REQ-020 SHALL treat in_sop and in_eop set on the same beat as a one-beat packet: out_sop = out_eop = 1, out_empty = 56 + in_empty.
REQ-021 SHALL drive in_ready low only in HOLD and during reset.

Reset
REQ-022 SHALL, while reset_n is low, force in_ready=0, out_valid=0, out_sop=0, out_eop=0, out_empty=0, out_data=0, err=0, lane counter 0 and state IDLE.
REQ-023 SHALL, on reset mid-packet, discard all partial and held data; no word is emitted after reset release until a new in_sop is accepted.
REQ-024 SHALL raise in_ready in the first clock edge after reset_n deasserts.

Configuration
REQ-025 SHALL, with ST_PACK_DOUBLE_BUF_EN defined, use a separate fill buffer and output register:
- A completed word moves to the output register when it is empty or is being accepted in the same cycle.
- HOLD is entered only when the output is full and not draining.
- Sustained throughput is one beat per cycle.
REQ-026 SHALL, without ST_PACK_DOUBLE_BUF_EN, use a single buffer:
- Every completed word enters HOLD until it is accepted.
- in_ready is low for at least one cycle per word, so the maximum throughput is 8 beats per 9 cycles.

Structure
REQ-027 SHALL take the lane count, width constants, and the state enum (IDLE/FILL/HOLD) from shared package st_adapter_pkg.
REQ-028 SHALL be a single module with no sub-modules; the lane writer is an inline generate loop.

Verification
REQ-029 SHALL pass this scenario: 8-beat packet, in_data = beat index, out_ready=1 -> one word with lane k = k, sop=1, eop=1, out_empty=in_empty.
REQ-030 SHALL pass this scenario: 3-beat packet with in_empty=2 -> lanes 3..7 zero, out_empty=42, sop=eop=1.
REQ-031 SHALL pass this scenario: 20-beat packet, out_ready=1 -> words of 8, 8 and 4 beats; sop only on the first word, eop only on the third; no cycle with in_ready low when double-buffered; one stall cycle per word when not.
REQ-032 SHALL pass this scenario: out_ready held low for 10 cycles after a completed word -> in_ready falls, out_data is stable, and no beat is lost.
REQ-033 SHALL pass this scenario: in_sop at lane 5 mid-packet -> err pulses once and the next word starts with the new beat in lane 0; a non-sop beat in IDLE -> err pulses and no output.
REQ-034 SHALL pass this scenario: reset_n asserted at lane 4 -> all outputs 0 and no stale word after release.
